// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply funct codes, multiplier latency and the
// per-stage record that flows through the multiply pipeline.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  localparam int unsigned MULT_LATENCY = 4;

  // Sized for four WIDTH-bit partial products at WIDTH = 32 (the widest payload, in P1).
  localparam int unsigned MULT_DATA_W = 128;

  typedef struct packed {
    logic                   valid;
    logic [4:0]             rd;
    logic                   is_signed;
    logic                   neg;        // product must be negated in P3
    logic [MULT_DATA_W-1:0] data;
  } mult_stage_t;

endpackage

// File: rtl/mult_stage.sv
// One registered multiply-pipeline stage; an empty or killed entry is held as all-zero
// so downstream tags and data read as 0 without extra gating.
module mult_stage
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_kill,
  input  mult_stage_t i_d,
  output mult_stage_t o_q
);

  mult_stage_t r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_kill || !i_d.valid) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mult_pipe.sv
// Four-stage pipelined MULT/MULTU unit: P1 partial products, P2 sum, P3 sign fix,
// R result, plus the architectural HI/LO registers.
module mult_pipe
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue_valid,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic [WIDTH-1:0] i_rt_data,
  input  logic [4:0]       i_rd,
  input  logic             i_flush,
  output logic [4:0]       o_p1_rd,
  output logic [4:0]       o_p2_rd,
  output logic [4:0]       o_p3_rd,
  output logic             o_mult_ready,
  output logic [4:0]       o_mult_rd,
  output logic [WIDTH-1:0] o_mult_result,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy
);

  localparam int unsigned HalfW = WIDTH / 2;
  localparam int unsigned ProdW = 2 * WIDTH;

  mult_stage_t w_p1_d, w_p2_d, w_p3_d, w_r_d;
  mult_stage_t w_p1_q, w_p2_q, w_p3_q, w_r_q;

  // WIDTH+1 bits so that -2^(WIDTH-1) has a representable magnitude.
  logic [WIDTH:0]     w_rs_ext, w_rt_ext, w_rs_mag, w_rt_mag;
  logic [HalfW-1:0]   w_a_lo, w_a_hi, w_b_lo, w_b_hi;
  logic [WIDTH-1:0]   w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh;
  logic [ProdW-1:0]   w_sum, w_mag;

  assign w_rs_ext = {i_signed & i_rs_data[WIDTH-1], i_rs_data};
  assign w_rt_ext = {i_signed & i_rt_data[WIDTH-1], i_rt_data};
  assign w_rs_mag = w_rs_ext[WIDTH] ? -w_rs_ext : w_rs_ext;
  assign w_rt_mag = w_rt_ext[WIDTH] ? -w_rt_ext : w_rt_ext;

  assign w_a_lo = w_rs_mag[HalfW-1:0];
  assign w_a_hi = w_rs_mag[WIDTH-1:HalfW];
  assign w_b_lo = w_rt_mag[HalfW-1:0];
  assign w_b_hi = w_rt_mag[WIDTH-1:HalfW];

  assign w_pp_ll = WIDTH'(w_a_lo) * WIDTH'(w_b_lo);
  assign w_pp_lh = WIDTH'(w_a_lo) * WIDTH'(w_b_hi);
  assign w_pp_hl = WIDTH'(w_a_hi) * WIDTH'(w_b_lo);
  assign w_pp_hh = WIDTH'(w_a_hi) * WIDTH'(w_b_hi);

  always_comb begin
    w_p1_d           = '0;
    w_p1_d.valid     = i_issue_valid;
    w_p1_d.rd        = i_rd;
    w_p1_d.is_signed = i_signed;
    w_p1_d.neg       = i_signed & (i_rs_data[WIDTH-1] ^ i_rt_data[WIDTH-1]);
    w_p1_d.data      = MULT_DATA_W'({w_pp_hh, w_pp_hl, w_pp_lh, w_pp_ll});
  end

  assign w_sum = ProdW'(w_p1_q.data[WIDTH-1:0])
               + (ProdW'(w_p1_q.data[2*WIDTH-1:WIDTH]) << HalfW)
               + (ProdW'(w_p1_q.data[3*WIDTH-1:2*WIDTH]) << HalfW)
               + (ProdW'(w_p1_q.data[4*WIDTH-1:3*WIDTH]) << WIDTH);

  always_comb begin
    w_p2_d      = w_p1_q;
    w_p2_d.data = MULT_DATA_W'(w_sum);
  end

  assign w_mag = w_p2_q.data[ProdW-1:0];

  always_comb begin
    w_p3_d      = w_p2_q;
    w_p3_d.data = MULT_DATA_W'(w_p2_q.neg ? -w_mag : w_mag);
  end

  assign w_r_d = w_p3_q;

  mult_stage u_p1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_kill (1'b0),
    .i_d    (w_p1_d),
    .o_q    (w_p1_q)
  );

  // A flush kills the op leaving P1; a same-cycle issue still enters P1.
  mult_stage u_p2 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_kill (i_flush),
    .i_d    (w_p2_d),
    .o_q    (w_p2_q)
  );

  mult_stage u_p3 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_kill (1'b0),
    .i_d    (w_p3_d),
    .o_q    (w_p3_q)
  );

  mult_stage u_r (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_kill (1'b0),
    .i_d    (w_r_d),
    .o_q    (w_r_q)
  );

  logic [WIDTH-1:0] r_hi, r_lo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_r_q.valid) begin
      r_hi <= w_r_q.data[ProdW-1:WIDTH];
      r_lo <= w_r_q.data[WIDTH-1:0];
    end
  end

  assign o_p1_rd       = w_p1_q.rd;
  assign o_p2_rd       = w_p2_q.rd;
  assign o_p3_rd       = w_p3_q.rd;
  assign o_mult_ready  = w_r_q.valid;
  assign o_mult_rd     = w_r_q.rd;
  assign o_mult_result = w_r_q.data[WIDTH-1:0];
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_busy        = w_p1_q.valid | w_p2_q.valid | w_p3_q.valid;

  // Magnitude MSB is always 0 and stage payloads are only partly consumed.
  logic w_unused;
  assign w_unused = ^{w_rs_mag[WIDTH], w_rt_mag[WIDTH], w_p1_q, w_p2_q, w_p3_q, w_r_q};

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed literal cases plus randomized traffic
// compared every cycle against an issue-history model of the pipeline.
module tb_mult_pipe;

  localparam int unsigned W    = 32;
  localparam int          NCYC = 2048;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_issue_valid = 1'b0;
  logic          i_signed = 1'b0;
  logic [W-1:0]  i_rs_data = '0;
  logic [W-1:0]  i_rt_data = '0;
  logic [4:0]    i_rd = '0;
  logic          i_flush = 1'b0;
  logic [4:0]    o_p1_rd, o_p2_rd, o_p3_rd, o_mult_rd;
  logic          o_mult_ready, o_busy;
  logic [W-1:0]  o_mult_result, o_hi, o_lo;

  always #5 i_clk = ~i_clk;

  mult_pipe #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (i_issue_valid),
    .i_signed      (i_signed),
    .i_rs_data     (i_rs_data),
    .i_rt_data     (i_rt_data),
    .i_rd          (i_rd),
    .i_flush       (i_flush),
    .o_p1_rd       (o_p1_rd),
    .o_p2_rd       (o_p2_rd),
    .o_p3_rd       (o_p3_rd),
    .o_mult_ready  (o_mult_ready),
    .o_mult_rd     (o_mult_rd),
    .o_mult_result (o_mult_result),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_busy        (o_busy)
  );

  // Per-cycle record of what was presented to the DUT.
  bit          m_iv [NCYC];
  bit          m_fl [NCYC];
  bit          m_rst[NCYC];
  logic [4:0]  m_rd [NCYC];
  logic [63:0] m_prod[NCYC];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  int cyc     = 0;
  int n_chk   = 0;
  int n_fail  = 0;
  bit running = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Op issued in cycle k is still alive when it would sit in stage s (cycle k+s).
  function automatic bit alive(input int k, input int s);
    if (k < 0) return 1'b0;
    if (!m_iv[k]) return 1'b0;
    for (int j = k; j < k + s; j++) if (m_rst[j]) return 1'b0;
    if (s >= 2 && m_fl[k+1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit iv, input bit sg, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] rd, input bit fl, input bit rst);
    logic [63:0] a, b;
    @(posedge i_clk);
    #1;
    cyc++;
    if (cyc >= NCYC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC);
      $fatal(1);
    end
    i_issue_valid = iv;
    i_signed      = sg;
    i_rs_data     = rs;
    i_rt_data     = rt;
    i_rd          = rd;
    i_flush       = fl;
    i_rst         = rst;
    a = sg ? {{32{rs[31]}}, rs} : {32'h0, rs};
    b = sg ? {{32{rt[31]}}, rt} : {32'h0, rt};
    m_iv[cyc]   = iv;
    m_fl[cyc]   = fl;
    m_rst[cyc]  = rst;
    m_rd[cyc]   = rd;
    m_prod[cyc] = a * b;
    running     = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge i_clk) begin
    int n;
    bit e_rdy;
    if (running) begin
      n     = cyc;
      e_rdy = alive(n - 4, 4);
      check("p1_rd", o_p1_rd, alive(n - 1, 1) ? m_rd[n-1] : 5'd0);
      check("p2_rd", o_p2_rd, alive(n - 2, 2) ? m_rd[n-2] : 5'd0);
      check("p3_rd", o_p3_rd, alive(n - 3, 3) ? m_rd[n-3] : 5'd0);
      check("ready", o_mult_ready, e_rdy);
      check("mult_rd", o_mult_rd, e_rdy ? m_rd[n-4] : 5'd0);
      check("result", o_mult_result, e_rdy ? m_prod[n-4][31:0] : 32'h0);
      check("hi", o_hi, m_hi);
      check("lo", o_lo, m_lo);
      check("busy", o_busy, alive(n - 1, 1) | alive(n - 2, 2) | alive(n - 3, 3));
      if (m_rst[n]) begin
        m_hi = '0;
        m_lo = '0;
      end else if (e_rdy) begin
        {m_hi, m_lo} = m_prod[n-4];
      end
    end
  end

  initial begin
    m_rst[0] = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    idle();
    @(negedge i_clk);
    check("rst_ready", o_mult_ready, 1'b0);
    check("rst_hi", o_hi, 32'h0);

    // MULTU 3 x 5, rd 9
    step(1'b1, 1'b0, 32'h3, 32'h5, 5'd9, 1'b0, 1'b0);
    idle(); @(negedge i_clk); check("t1_p1", o_p1_rd, 5'd9);
    idle(); @(negedge i_clk); check("t1_p2", o_p2_rd, 5'd9);
    idle(); @(negedge i_clk); check("t1_p3", o_p3_rd, 5'd9);
    idle(); @(negedge i_clk);
    check("t1_ready", o_mult_ready, 1'b1);
    check("t1_rd", o_mult_rd, 5'd9);
    check("t1_result", o_mult_result, 32'd15);
    idle(); @(negedge i_clk);
    check("t1_hi", o_hi, 32'h0);
    check("t1_lo", o_lo, 32'd15);

    // MULT -1 x 2
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h2, 5'd10, 1'b0, 1'b0);
    repeat (4) idle();
    @(negedge i_clk); check("t2_result", o_mult_result, 32'hFFFF_FFFE);
    idle(); @(negedge i_clk);
    check("t2_hi", o_hi, 32'hFFFF_FFFF);
    check("t2_lo", o_lo, 32'hFFFF_FFFE);

    // MULT -2^31 x -2^31
    step(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd11, 1'b0, 1'b0);
    repeat (5) idle();
    @(negedge i_clk);
    check("t3_hi", o_hi, 32'h4000_0000);
    check("t3_lo", o_lo, 32'h0);

    // Back-to-back rd 4, 5, 6
    step(1'b1, 1'b0, 32'd7, 32'd6, 5'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd3, 5'd5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6, 1'b0, 1'b0);
    idle(); @(negedge i_clk);
    check("t4_p1", o_p1_rd, 5'd6);
    check("t4_p2", o_p2_rd, 5'd5);
    check("t4_p3", o_p3_rd, 5'd4);
    for (int i = 0; i < 3; i++) begin
      idle(); @(negedge i_clk);
      check("t4_ready", o_mult_ready, 1'b1);
      check("t4_rd", o_mult_rd, 5'(4 + i));
    end
    idle(); @(negedge i_clk); check("t4_done", o_mult_ready, 1'b0);

    // Flush rd 7 while issuing rd 8
    step(1'b1, 1'b0, 32'd2, 32'd3, 5'd7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd4, 32'd4, 5'd8, 1'b1, 1'b0);
    idle(); @(negedge i_clk);
    check("t5_p2_empty", o_p2_rd, 5'd0);
    check("t5_p1", o_p1_rd, 5'd8);
    idle(); @(negedge i_clk); check("t5_p2", o_p2_rd, 5'd8);
    idle(); @(negedge i_clk); check("t5_no_rd7", o_mult_ready, 1'b0);
    idle(); @(negedge i_clk);
    check("t5_ready", o_mult_ready, 1'b1);
    check("t5_rd", o_mult_rd, 5'd8);
    check("t5_result", o_mult_result, 32'd16);

    // Reset two cycles after issuing rd 3
    step(1'b1, 1'b0, 32'd9, 32'd9, 5'd3, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    idle(); @(negedge i_clk);
    check("t6_p1", o_p1_rd, 5'd0);
    check("t6_p2", o_p2_rd, 5'd0);
    check("t6_p3", o_p3_rd, 5'd0);
    check("t6_hi", o_hi, 32'h0);
    check("t6_lo", o_lo, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("t6_ready", o_mult_ready, 1'b0);
      idle(); @(negedge i_clk);
    end

    // Randomized traffic with flushes and occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 10) < 7, 1'($urandom), pick(), pick(), 5'($urandom),
           ($urandom % 10) == 0, ($urandom % 64) == 0);
    end
    repeat (6) idle();
    @(negedge i_clk);
    #1;
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; product is 2*WIDTH.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_issue_valid  input  1  multiply issued from EX this cycle.
REQ-005 SHALL have port i_signed  input  1  1 = MULT (signed), 0 = MULTU.
REQ-006 SHALL have ports i_rs_data and i_rt_data  input  WIDTH  operands.
REQ-007 SHALL have port i_rd  input  5  destination register tag carried with the op.
REQ-008 SHALL have port i_flush  input  1  kill the op currently in stage P1.
REQ-009 SHALL have ports o_p1_rd, o_p2_rd and o_p3_rd  output  5  per-stage destination tags, consumed by the ID-stage hazard logic.
REQ-010 SHALL have port o_mult_ready  output  1  result valid this cycle.
REQ-011 SHALL have port o_mult_rd  output  5  destination of the completing op.
REQ-012 SHALL have port o_mult_result  output  WIDTH  low half of the completing product.
REQ-013 SHALL have ports o_hi and o_lo  output  WIDTH  architectural HI/LO registers.
REQ-014 SHALL have port o_busy  output  1  OR of the P1..P3 valid bits.

Function
REQ-015 SHALL be fully pipelined: stages P1, P2, P3, then R (result), each holding a valid bit, rd, signed flag and partial data; accepts one issue per cycle.
REQ-016 Issue in cycle N SHALL occupy P1 in N+1, P2 in N+2 and P3 in N+3, and assert o_mult_ready in N+4; fixed latency 4, no back-pressure.
REQ-017 P1 SHALL compute four (WIDTH/2)x(WIDTH/2) unsigned partial products of operand magnitudes.
REQ-018 P2 SHALL sum the partial products into a 2*WIDTH magnitude.
REQ-019 P3 SHALL apply two's-complement negation when i_signed was set and the operand signs differed.
REQ-020 Signed -2^(WIDTH-1) operands SHALL be handled by using a WIDTH+1-bit magnitude; no overflow is reported.
REQ-021 Each o_pN_rd SHALL equal that stage's rd when the stage is valid, and 5'd0 when it is empty.
REQ-022 o_mult_ready SHALL be the R valid bit; o_mult_rd and o_mult_result SHALL be 0 when o_mult_ready=0.
REQ-023 In the cycle R becomes valid, o_hi/o_lo SHALL load the product's upper/lower halves, registered, and become visible the next cycle; o_mult_result is driven from R, not from o_lo.
REQ-024 An op with rd=0 SHALL flow normally and update HI/LO; consumers ignore the tag.
REQ-025 i_flush SHALL clear the P1 valid bit at the next edge; ops already in P2/P3 are unaffected.
REQ-026 When i_flush and i_issue_valid are both set, the new issue SHALL still enter P1.
REQ-027 Back-to-back issues SHALL complete in order on consecutive cycles, each with its own rd.
REQ-028 An identical rd in two stages SHALL be allowed; each stage reports its rd independently.

Reset
REQ-029 i_rst SHALL clear all valid bits, all tags, o_hi, o_lo and o_mult_result to 0 at the next edge.
REQ-030 An issue presented in a reset cycle SHALL be discarded.
REQ-031 Reset asserted mid-operation SHALL drop all in-flight ops; no o_mult_ready follows.

Structure
REQ-032 The shared package mips_pkg SHALL hold the MULT/MULTU/MFLO/MFHI funct constants, MULT_LATENCY=4 and the mult_stage_t typedef (valid, rd, signed, data).
REQ-033 One sub-module, mult_stage, SHALL implement a single registered stage with synchronous active-high clear and a kill input; it is instantiated for P1, P2, P3 and R.
REQ-034 The module SHALL contain no combinational path from the inputs to any output.

Verification
REQ-035 Reset, then issue MULTU 0x0000_0003 x 0x0000_0005 with rd=9 -> p1/p2/p3_rd=9 in cycles +1/+2/+3; in cycle +4 ready=1, rd=9, result=15; next cycle hi=0, lo=15.
REQ-036 Issue MULT 0xFFFF_FFFF x 0x0000_0002 (signed) -> result=0xFFFF_FFFE; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFE.
REQ-037 Issue MULT 0x8000_0000 x 0x8000_0000 -> hi=0x4000_0000, lo=0x0000_0000.
REQ-038 Issue three back-to-back ops with rd=4, 5, 6 -> ready for 3 consecutive cycles with rd 4, 5, 6; p1/p2/p3_rd=6/5/4 in the same cycle.
REQ-039 Issue with rd=7, flush next cycle together with a new issue of rd=8 -> only rd=8 completes; rd=7 never appears on o_p2_rd.
REQ-040 Issue with rd=3, then assert i_rst two cycles later -> all tags 0, no ready, hi=lo=0.
